// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send byte transmitter between NUM_REQ sources.
// Define UART_ARB_FIXED_PRIO_EN to select fixed lowest-index-first priority instead.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 0,
  parameter int IDW        = $clog2(NUM_REQ)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_en,
  output logic [7:0]           uart_din,
  input  logic                 uart_tx_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 arb_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ACK,
    S_WAIT,
    S_GAP
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [15:0]  gap_q;
  logic [IDW-1:0] win;
  logic         any_req;
  logic         fire;

`ifdef UART_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = |req_valid;
    win     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win = IDW'(i);
    end
  end
`else
  logic [IDW-1:0]     ptr_q;
  logic [NUM_REQ-1:0] hi_req;

  // Requests above the pointer take precedence; otherwise wrap to the lowest.
  always_comb begin
    any_req = |req_valid;
    win     = '0;
    hi_req  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_req[i] = req_valid[i] && (i > int'(ptr_q));
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) win = IDW'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hi_req[i]) win = IDW'(i);
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (!sys_rst && state_q == S_IDLE && !uart_tx_busy && any_req) begin
      req_ready[win] = 1'b1;
    end
  end

  assign fire     = |(req_valid & req_ready);
  assign arb_busy = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (fire) state_d = S_START;
      S_START: state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      S_WAIT: begin
        if (!uart_tx_busy) state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP:   if (gap_q == 16'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= S_IDLE;
      gap_q    <= '0;
      uart_en  <= 1'b0;
      uart_din <= '0;
      grant_id <= '0;
`ifndef UART_ARB_FIXED_PRIO_EN
      ptr_q    <= IDW'(NUM_REQ - 1);
`endif
    end else begin
      state_q <= state_d;
      uart_en <= (state_d == S_START);
      if (fire) begin
        uart_din <= req_data[{win, 3'b000} +: 8];
        grant_id <= win;
`ifndef UART_ARB_FIXED_PRIO_EN
        ptr_q    <= win;
`endif
      end
      if (state_q == S_WAIT && state_d == S_GAP) begin
        gap_q <= 16'(GAP_CYCLES - 1);
      end else if (state_q == S_GAP) begin
        gap_q <= gap_q - 16'd1;
      end
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_send byte transmitter between NUM_REQ byte sources.
- Round-robin arbitration between sources.
- Per-source valid/ready handshake.
- Sequences the transmitter's rising-edge-triggered uart_en / uart_din / uart_tx_busy interface, one byte per frame.
- Sits between producer logic (status reporters, command responders) and uart_send.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
GAP_CYCLES, 0, idle sys_clk cycles inserted after each frame before the next grant; legal range 0..65535.
IDW, $clog2(NUM_REQ), width of grant_id (derived; not overridden).

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
sys_rst  in  1  synchronous, active-high reset.
req_valid  in  NUM_REQ  bit i high: requester i presents a byte; held until accepted.
req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]; stable while req_valid[i] is high.
req_ready  out  NUM_REQ  combinational one-hot accept; transfer happens when req_valid[i] & req_ready[i].
uart_en  out  1  registered; one-cycle pulse that starts a frame in uart_send.
uart_din  out  8  registered byte to transmitter; held from pulse until the frame completes.
uart_tx_busy  in  1  transmitter busy flag.
grant_id  out  IDW  index of the last accepted requester.
arb_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: uart_en=0, uart_din=0, grant_id=0, req_ready=0, arb_busy=0.
- Reset also sets: state=IDLE, rr pointer=NUM_REQ-1 (requester 0 has highest priority first), gap counter=0.
- A sys_rst asserted mid-frame aborts sequencing immediately. The transmitter's own frame is not this block's concern.
- After reset, the block waits for uart_tx_busy=0 in IDLE before granting.

State machine (one state register):
- IDLE:
  - req_ready nonzero only here, and only if uart_tx_busy=0.
  - Winner = first i with req_valid[i]=1, searching from pointer+1 upward and wrapping modulo NUM_REQ.
  - req_ready = onehot(winner) when any valid; otherwise 0.
  - On transfer: register uart_din<=req_data[winner], grant_id<=winner, pointer<=winner; go to START.
- START: uart_en=1 for exactly this cycle; go to ACK.
- ACK: uart_en=0. The transmitter samples uart_din here. Go to WAIT.
- WAIT: stay while uart_tx_busy=1. On uart_tx_busy=0, go to GAP if GAP_CYCLES>0 and load counter=GAP_CYCLES-1; otherwise go to IDLE.
- GAP: decrement counter; go to IDLE when counter==0.

Timing and invariants:
- Latency: accept at cycle t -> uart_en high at t+1 -> earliest next accept at the cycle after uart_tx_busy falls, plus GAP_CYCLES.
- uart_din must not change between START and exit from WAIT.
- uart_en is low for at least 2 cycles between pulses. This guarantees a fresh rising edge for uart_send.
- A req_valid deasserted before acceptance is simply not granted; no error is raised.
- Valid changes outside IDLE are ignored.
- Simultaneous requests: exactly one accepted per frame.
- Fairness: with all NUM_REQ continuously valid, each requester is served exactly once per NUM_REQ consecutive frames.
- Counter widths: gap counter is 16 bits; pointer is IDW bits, wrapping at NUM_REQ-1 -> 0 (including non-power-of-2 NUM_REQ).

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Winner = lowest index with req_valid set; the pointer is not used or updated, and grant_id is still reported.
- Undefined (default): round-robin as described above.
- The handshake and the uart sequencing are identical in both modes.

Test Plan:
- Bench pairs this block with uart_send at BPS_CNT=16.
- Single source: req_valid=0001, req_data[7:0]=0xA5 -> req_ready=0001 for one cycle; uart_en pulses 1 cycle later; uart_din=0xA5 held until busy drops; line shows 0,1,0,1,0,0,1,0,1,1.
- Round-robin: req_valid=1111 held with bytes 0x10,0x11,0x12,0x13 -> grant_id sequence 0,1,2,3,0; exactly one uart_en per frame.
- Wrap/skip: NUM_REQ=3, pointer=1, req_valid=101 -> requester 2 granted, then 0; grant_id never equals 3.
- Fixed priority (macro defined): req_valid=1010 continuously -> requester 1 granted every frame; requester 3 is starved.
- Gap and reset: GAP_CYCLES=5 -> next req_ready no earlier than 5 cycles after uart_tx_busy falls. Then sys_rst asserted in WAIT -> next cycle uart_en=0, uart_din=0, arb_busy=0, and first post-reset grant goes to requester 0.
